// File: rtl/outpass4_frame_config_ser.sv
// -----------------------------------------------------------------------------
// outpass4_frame_config_ser
//
// Output-direction pass BEL. Four fabric signals I0..I3 go to four external
// pad-side outputs O0..O3.
//
// Parallel mode (ConfigBits[4]=0): each channel is either combinational
// (Ox = Ix) or registered on UserCLK (Ox = Qx), chosen by ConfigBits[x].
//
// Serial mode (ConfigBits[4]=1): an LD strobe captures {I3,I2,I1,I0}. The
// word is then shifted out on O0, one bit per cycle. The qualifiers are:
//   O1 frame valid, O2 first-bit marker, O3 busy mirror.
// BUSY reports an in-progress frame back to the fabric. An LD on the final
// cycle of a frame starts the next frame with no idle cycle in between.
//
// Optional feature macro: OUTPASS4_SER_PARITY_EN
//   When defined, an even-parity bit follows the four data bits. This gives
//   5-cycle frames.
//
// Ports
//   UserCLK    in   user clock (external, shared)
//   RESETn     in   synchronous active-low reset
//   I0..I3     in   fabric data from the switch matrix
//   LD         in   fabric load strobe (serial mode only)
//   BUSY       out  high while a serial frame is in progress
//   O0..O3     out  pad-side outputs
//   ConfigBits in   [3:0] per-channel registered select, [4] serial enable,
//                   [5] bit order (0 = I0 first, 1 = I3 first)
// -----------------------------------------------------------------------------
module outpass4_frame_config_ser #(
  parameter int NoConfigBits = 6
) (
  input  logic                    UserCLK,
  input  logic                    RESETn,
  input  logic                    I0,
  input  logic                    I1,
  input  logic                    I2,
  input  logic                    I3,
  input  logic                    LD,
  output logic                    BUSY,
  output logic                    O0,
  output logic                    O1,
  output logic                    O2,
  output logic                    O3,
  input  logic [NoConfigBits-1:0] ConfigBits
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1
`ifdef OUTPASS4_SER_PARITY_EN
    ,
    PARITY = 2'd2
`endif
  } serState_t;

  serState_t   state;
  serState_t   stateNext;
  logic [3:0]  iVec;
  logic [3:0]  q;
  logic [3:0]  shreg;
  logic [1:0]  cnt;
  logic        load;
  logic        serialEn;
  logic        msbFirst;
  logic        curBit;
  logic [3:0]  serOut;
  logic [3:0]  parOut;
  logic [3:0]  oVec;

  assign iVec     = {I3, I2, I1, I0};
  assign serialEn = ConfigBits[4];
  assign msbFirst = ConfigBits[5];

  // Next-state logic. An LD is accepted only in IDLE or on the last cycle of
  // a frame. An LD at any other point in a frame is dropped on purpose.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    stateNext = state;
    load      = 1'b0;
    if (!serialEn) begin
      stateNext = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (LD) begin
            load      = 1'b1;
            stateNext = SHIFT;
          end
        end
        SHIFT: begin
          if (cnt == 2'd3) begin
`ifdef OUTPASS4_SER_PARITY_EN
            stateNext = PARITY;
`else
            if (LD) begin
              load      = 1'b1;
              stateNext = SHIFT;
            end else begin
              stateNext = IDLE;
            end
`endif
          end
        end
`ifdef OUTPASS4_SER_PARITY_EN
        PARITY: begin
          if (LD) begin
            load      = 1'b1;
            stateNext = SHIFT;
          end else begin
            stateNext = IDLE;
          end
        end
`endif
        default: stateNext = IDLE;
      endcase
    end
  end

  always_ff @(posedge UserCLK) begin
    // NOTE: the reset here is synchronous, so it is only seen at a clock edge.
    // It clears every state bit, including the shift register, so no stale
    // word can leak out after reset.
    if (!RESETn) begin
      // NOTE: state elements take non-blocking assignments, so every
      // register samples the values from before the edge.
      q     <= 4'b0;
      shreg <= 4'b0;
      cnt   <= 2'd0;
      state <= IDLE;
    end else begin
      // Qx follows Ix on every edge. When serial mode is switched off, the
      // registered channels then show the last-sampled input at once.
      q     <= iVec;
      state <= stateNext;
      if (load) begin
        shreg <= iVec;
        cnt   <= 2'd0;
      end else if (state == SHIFT) begin
        cnt <= cnt + 2'd1;
      end
    end
  end

  // Serial outputs are pure functions of registered state, so they change
  // only after a clock edge.
  always_comb begin
    serOut = 4'b0;
    curBit = msbFirst ? shreg[2'd3 - cnt] : shreg[cnt];
    case (state)
      SHIFT:  serOut = {1'b1, (cnt == 2'd0), 1'b1, curBit};
`ifdef OUTPASS4_SER_PARITY_EN
      PARITY: serOut = {1'b1, 1'b0, 1'b1, ^shreg};
`endif
      default: serOut = 4'b0;
    endcase
  end

  // Parallel channels bypass reset when combinational.
  assign parOut = (ConfigBits[3:0] & q) | (~ConfigBits[3:0] & iVec);
  assign oVec   = serialEn ? serOut : parOut;

  assign O0   = oVec[0];
  assign O1   = oVec[1];
  assign O2   = oVec[2];
  assign O3   = oVec[3];
  assign BUSY = (state != IDLE);

endmodule

// File: tb/tb_outpass4_frame_config_ser.sv
// -----------------------------------------------------------------------------
// tb_outpass4_frame_config_ser
//
// Self-checking bench for outpass4_frame_config_ser.
//
// The reference model tracks the serial frame as a position (idle, data bit
// 0..3, parity). It also tracks the captured word and the last-sampled
// inputs. A compare process checks {BUSY,O3,O2,O1,O0} on every falling edge.
// Directed sequences also check hand-computed literal vectors.
// -----------------------------------------------------------------------------
module tb_outpass4_frame_config_ser;

`ifdef OUTPASS4_SER_PARITY_EN
  localparam int LastPos = 4;
`else
  localparam int LastPos = 3;
`endif

  logic       UserCLK = 1'b0;
  logic       RESETn;
  logic [3:0] iVec;
  logic       LD;
  logic [5:0] cfg;
  logic       BUSY, O0, O1, O2, O3;

  int nCompared   = 0;
  int nMismatched = 0;
  bit checkEn     = 1'b0;

  // Reference model state
  int         pos   = -1;   // -1 idle, 0..3 data bit, 4 parity
  logic [3:0] word  = 4'b0;
  logic [3:0] qMod  = 4'b0;

  outpass4_frame_config_ser #(.NoConfigBits(6)) dut (
    .UserCLK    (UserCLK),
    .RESETn     (RESETn),
    .I0         (iVec[0]),
    .I1         (iVec[1]),
    .I2         (iVec[2]),
    .I3         (iVec[3]),
    .LD         (LD),
    .BUSY       (BUSY),
    .O0         (O0),
    .O1         (O1),
    .O2         (O2),
    .O3         (O3),
    .ConfigBits (cfg)
  );

  always #5 UserCLK = ~UserCLK;

  task automatic check(input string name, input logic [4:0] act, input logic [4:0] expv);
    nCompared++;
    if (act !== expv) begin
      nMismatched++;
      $display("FAIL %s at %0t: got %b expected %b ({BUSY,O3,O2,O1,O0})", name, $time, act, expv);
    end
  endtask

  // The model advances once per rising edge, using the inputs held across it.
  task automatic model_step();
    if (!RESETn) begin
      pos  = -1;
      qMod = 4'b0;
    end else begin
      qMod = iVec;
      if (!cfg[4]) begin
        pos = -1;
      end else if (pos == -1 || pos == LastPos) begin
        if (LD) begin
          word = iVec;
          pos  = 0;
        end else begin
          pos = -1;
        end
      end else begin
        pos = pos + 1;
      end
    end
  endtask

  function automatic logic [4:0] model_out();
    logic [4:0] r;
    int idx;
    r = 5'b0;
    if (!cfg[4]) begin
      for (int x = 0; x < 4; x++) r[x] = cfg[x] ? qMod[x] : iVec[x];
      r[4] = (pos >= 0);
    end else if (pos >= 0 && pos <= 3) begin
      idx  = cfg[5] ? 3 - pos : pos;
      r    = {1'b1, 1'b1, (pos == 0), 1'b1, word[idx]};
    end else if (pos == 4) begin
      r    = {1'b1, 1'b1, 1'b0, 1'b1, ^word};
    end
    return r;
  endfunction

  always @(negedge UserCLK) begin
    if (checkEn) check("model", {BUSY, O3, O2, O1, O0}, model_out());
  end

  // Advances one cycle: model update at the edge, then new inputs.
  task automatic drive(input logic [3:0] i, input logic ld, input logic [5:0] c, input logic r);
    @(posedge UserCLK);
    model_step();
    #1;
    iVec   = i;
    LD     = ld;
    cfg    = c;
    RESETn = r;
  endtask

  task automatic step_chk(input logic [3:0] i, input logic ld, input logic [5:0] c,
                          input logic r, input logic [4:0] expv, input string name);
    drive(i, ld, c, r);
    @(negedge UserCLK);
    check(name, {BUSY, O3, O2, O1, O0}, expv);
  endtask

  localparam logic [5:0] SerLsb = 6'b010000;
  localparam logic [5:0] SerMsb = 6'b110000;

  initial begin
    iVec = 4'b0; LD = 1'b0; cfg = SerLsb; RESETn = 1'b0;
    drive(4'hA, 1'b0, SerLsb, 1'b0);
    step_chk(4'hA, 1'b0, SerLsb, 1'b1, 5'b00000, "reset_state");
    checkEn = 1'b1;

    // Parallel mix: channels 0 and 2 registered, 1 and 3 combinational
    step_chk(4'h0, 1'b0, 6'b000101, 1'b1, 5'b00000, "par_zero");
    step_chk(4'hF, 1'b0, 6'b000101, 1'b1, 5'b01010, "par_comb_now");
    step_chk(4'hF, 1'b0, 6'b000101, 1'b1, 5'b01111, "par_reg_later");

    // Serial LSB-first, word 1011
    step_chk(4'b1011, 1'b1, SerLsb, 1'b1, 5'b00000, "lsb_ld");
    step_chk(4'b0000, 1'b0, SerLsb, 1'b1, 5'b11111, "lsb_b0");
    step_chk(4'b0000, 1'b0, SerLsb, 1'b1, 5'b11011, "lsb_b1");
    step_chk(4'b0000, 1'b0, SerLsb, 1'b1, 5'b11010, "lsb_b2");
    step_chk(4'b0000, 1'b0, SerLsb, 1'b1, 5'b11011, "lsb_b3");
`ifdef OUTPASS4_SER_PARITY_EN
    step_chk(4'b0000, 1'b0, SerLsb, 1'b1, 5'b11011, "lsb_parity");
`endif
    step_chk(4'b0000, 1'b0, SerLsb, 1'b1, 5'b00000, "lsb_idle");

    // Serial MSB-first, word 1011: bits 1,0,1,1
    step_chk(4'b1011, 1'b1, SerMsb, 1'b1, 5'b00000, "msb_ld");
    step_chk(4'b0000, 1'b0, SerMsb, 1'b1, 5'b11111, "msb_b0");
    step_chk(4'b0000, 1'b0, SerMsb, 1'b1, 5'b11010, "msb_b1");
    step_chk(4'b0000, 1'b0, SerMsb, 1'b1, 5'b11011, "msb_b2");
    step_chk(4'b0000, 1'b0, SerMsb, 1'b1, 5'b11011, "msb_b3");
`ifdef OUTPASS4_SER_PARITY_EN
    step_chk(4'b0000, 1'b0, SerMsb, 1'b1, 5'b11011, "msb_parity");
`endif

    // LD mid-frame is ignored; LD on the last cycle chains the next frame
    step_chk(4'b1011, 1'b1, SerLsb, 1'b1, 5'b00000, "b2b_ld");
    step_chk(4'b1111, 1'b1, SerLsb, 1'b1, 5'b11111, "b2b_b0");
    step_chk(4'b0000, 1'b0, SerLsb, 1'b1, 5'b11011, "b2b_b1_ignld");
    step_chk(4'b0000, 1'b0, SerLsb, 1'b1, 5'b11010, "b2b_b2");
`ifdef OUTPASS4_SER_PARITY_EN
    step_chk(4'b0000, 1'b0, SerLsb, 1'b1, 5'b11011, "b2b_b3");
    step_chk(4'b0110, 1'b1, SerLsb, 1'b1, 5'b11011, "b2b_parity_ld");
`else
    step_chk(4'b0110, 1'b1, SerLsb, 1'b1, 5'b11011, "b2b_b3_ld");
`endif
    step_chk(4'b0000, 1'b0, SerLsb, 1'b1, 5'b11110, "b2b_n0");
    step_chk(4'b0000, 1'b0, SerLsb, 1'b1, 5'b11011, "b2b_n1");
    step_chk(4'b0000, 1'b0, SerLsb, 1'b1, 5'b11011, "b2b_n2");
    step_chk(4'b0000, 1'b0, SerLsb, 1'b1, 5'b11010, "b2b_n3");
`ifdef OUTPASS4_SER_PARITY_EN
    step_chk(4'b0000, 1'b0, SerLsb, 1'b1, 5'b11010, "b2b_n_parity0");
`endif
    step_chk(4'b0000, 1'b0, SerLsb, 1'b1, 5'b00000, "b2b_idle");

    // Reset on the second bit
    step_chk(4'b1011, 1'b1, SerLsb, 1'b1, 5'b00000, "rst_ld");
    step_chk(4'b0000, 1'b0, SerLsb, 1'b1, 5'b11111, "rst_b0");
    step_chk(4'b0000, 1'b0, SerLsb, 1'b0, 5'b11011, "rst_b1");
    step_chk(4'b0000, 1'b0, SerLsb, 1'b1, 5'b00000, "rst_after");

    // Serial mode cleared mid-frame: parallel path at once, BUSY low next edge
    step_chk(4'b1011, 1'b1, SerLsb, 1'b1, 5'b00000, "abort_ld");
    step_chk(4'b0000, 1'b0, SerLsb, 1'b1, 5'b11111, "abort_b0");
    step_chk(4'b0101, 1'b0, 6'b000011, 1'b1, 5'b10100, "abort_par_now");
    step_chk(4'b0101, 1'b0, 6'b000011, 1'b1, 5'b00101, "abort_par_next");

    // Randomized phase, checked by the model every cycle
    for (int n = 0; n < 600; n++) begin
      logic [5:0] c;
      c = cfg;
      if ($urandom_range(0, 19) == 0) c[4] = ~c[4];
      if ($urandom_range(0, 29) == 0) c[5] = ~c[5];
      if ($urandom_range(0, 9) == 0)  c[3:0] = 4'($urandom);
      drive(4'($urandom), ($urandom_range(0, 2) == 0), c, ($urandom_range(0, 49) != 0));
    end

    @(negedge UserCLK);
    checkEn = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
